// File: rtl/digit_tile_renderer_if.sv
// Pixel-stream bundle between the VGA timing source (master) and the digit tile renderer (slave).
interface digit_tile_renderer_if;
   logic [9:0] sx;
   logic [9:0] sy;
   logic       de;
   logic       frame_start;
   logic [2:0] vga_r;
   logic [2:0] vga_g;
   logic [1:0] vga_b;
   logic       de_out;

   modport master (
      output sx, sy, de, frame_start,
      input  vga_r, vga_g, vga_b, de_out
   );

   modport slave (
      input  sx, sy, de, frame_start,
      output vga_r, vga_g, vga_b, de_out
   );
endinterface

// File: rtl/digit_tile_renderer.sv
// Draws a ROWS x COLS grid of nibbles as seven-segment glyphs with a fixed 2-clock pixel latency.
// Cursor blink/inversion is built only when DIGIT_TILE_CURSOR_EN is defined.
module digit_tile_renderer #(
   parameter int COLS         = 6,
   parameter int ROWS         = 2,
   parameter int TILE_W       = 80,
   parameter int TILE_H       = 140,
   parameter int X0           = 20,
   parameter int Y0           = 20,
   parameter int X_PITCH      = 100,
   parameter int Y_PITCH      = 180,
   parameter int SEG_T        = 10,
   parameter int BLINK_FRAMES = 30
) (
   input  logic                     clk,
   input  logic                     rst_n,
   digit_tile_renderer_if.slave     vid,
   input  logic [4*ROWS*COLS-1:0]   numbers_concat,
   input  logic                     cursor_en,
   input  logic [((ROWS*COLS > 1) ? $clog2(ROWS*COLS) : 1)-1:0] cursor_idx
);

   localparam int N = ROWS * COLS;

   logic [4*N-1:0] shadow;

   // Values are only taken at frame_start so a frame never mixes old and new digits.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shadow <= {N{4'hF}};
      end else if (vid.frame_start) begin
         shadow <= numbers_concat;
      end
   end

   logic       hit_c;
   logic [3:0] digit_c;
   logic [9:0] x_off_c;
   logic [9:0] y_off_c;
   logic       cur_c;

   always_comb begin
      hit_c   = 1'b0;
      digit_c = 4'h0;
      x_off_c = 10'd0;
      y_off_c = 10'd0;
      cur_c   = 1'b0;
      for (int r = 0; r < ROWS; r++) begin
         for (int c = 0; c < COLS; c++) begin
            if (int'(vid.sx) >= X0 + c*X_PITCH && int'(vid.sx) < X0 + c*X_PITCH + TILE_W &&
                int'(vid.sy) >= Y0 + r*Y_PITCH && int'(vid.sy) < Y0 + r*Y_PITCH + TILE_H) begin
               hit_c   = 1'b1;
               digit_c = shadow[4*(N-1-(r*COLS+c)) +: 4];
               x_off_c = 10'(int'(vid.sx) - (X0 + c*X_PITCH));
               y_off_c = 10'(int'(vid.sy) - (Y0 + r*Y_PITCH));
`ifdef DIGIT_TILE_CURSOR_EN
               cur_c   = cursor_en && (int'(cursor_idx) == r*COLS + c);
`endif
            end
         end
      end
   end

   logic       s1_hit;
   logic [3:0] s1_digit;
   logic [9:0] s1_x;
   logic [9:0] s1_y;
   logic       s1_cur;
   logic       s1_de;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_hit   <= 1'b0;
         s1_digit <= 4'h0;
         s1_x     <= 10'd0;
         s1_y     <= 10'd0;
         s1_cur   <= 1'b0;
         s1_de    <= 1'b0;
      end else begin
         s1_hit   <= hit_c;
         s1_digit <= digit_c;
         s1_x     <= x_off_c;
         s1_y     <= y_off_c;
         s1_cur   <= cur_c;
         s1_de    <= vid.de;
      end
   end

   // Segment order in both vectors is {a,b,c,d,e,f,g}.
   logic       top_half;
   logic [6:0] seg_zone;
   logic [6:0] seg_pattern;
   logic       seg_lit;

   always_comb begin
      top_half = s1_y < 10'(TILE_H/2);
      seg_zone = {
         s1_y <  10'(SEG_T),
         (s1_x >= 10'(TILE_W - SEG_T)) &&  top_half,
         (s1_x >= 10'(TILE_W - SEG_T)) && !top_half,
         s1_y >= 10'(TILE_H - SEG_T),
         (s1_x <  10'(SEG_T)) && !top_half,
         (s1_x <  10'(SEG_T)) &&  top_half,
         (s1_y >= 10'((TILE_H - SEG_T)/2)) && (s1_y < 10'((TILE_H + SEG_T)/2))
      };
      case (s1_digit)
         4'h0:    seg_pattern = 7'b1111110;
         4'h1:    seg_pattern = 7'b0110000;
         4'h2:    seg_pattern = 7'b1101101;
         4'h3:    seg_pattern = 7'b1111001;
         4'h4:    seg_pattern = 7'b0110011;
         4'h5:    seg_pattern = 7'b1011011;
         4'h6:    seg_pattern = 7'b1011111;
         4'h7:    seg_pattern = 7'b1110000;
         4'h8:    seg_pattern = 7'b1111111;
         4'h9:    seg_pattern = 7'b1111011;
         4'hA:    seg_pattern = 7'b0000001;
         default: seg_pattern = 7'b0000000;
      endcase
      seg_lit = |(seg_zone & seg_pattern);
   end

   logic invert;

`ifdef DIGIT_TILE_CURSOR_EN
   localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   // Down-counter holds frames remaining in the current blink phase.
   logic [BW-1:0] blink_left;
   logic          blink_phase;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         blink_left  <= BW'(BLINK_FRAMES - 1);
         blink_phase <= 1'b0;
      end else if (vid.frame_start) begin
         if (blink_left == '0) begin
            blink_left  <= BW'(BLINK_FRAMES - 1);
            blink_phase <= ~blink_phase;
         end else begin
            blink_left  <= blink_left - 1'b1;
         end
      end
   end

   assign invert = s1_hit && s1_cur && blink_phase;
`else
   logic unused_cursor;
   assign unused_cursor = ^{cursor_en, cursor_idx, s1_cur};
   assign invert = 1'b0;
`endif

   logic pix_on;
   assign pix_on = s1_de && ((s1_hit && seg_lit) ^ invert);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vid.vga_r  <= 3'd0;
         vid.vga_g  <= 3'd0;
         vid.vga_b  <= 2'd0;
         vid.de_out <= 1'b0;
      end else begin
         vid.vga_r  <= pix_on ? 3'd7 : 3'd0;
         vid.vga_g  <= pix_on ? 3'd7 : 3'd0;
         vid.vga_b  <= pix_on ? 2'd3 : 2'd0;
         vid.de_out <= s1_de;
      end
   end

endmodule

// File: tb/tb_digit_tile_renderer.sv
// Bench for digit_tile_renderer: directed test-plan points plus random pixels against a tile/glyph model.
module tb_digit_tile_renderer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [47:0] nums;
   logic        cursor_en;
   logic [3:0]  cursor_idx;

   digit_tile_renderer_if vid ();

   digit_tile_renderer dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .vid            (vid),
      .numbers_concat (nums),
      .cursor_en      (cursor_en),
      .cursor_idx     (cursor_idx)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] rgb;
      logic       de;
      string      tag;
   } exp_t;

   exp_t       q[$];
   int         checks = 0;
   int         failures = 0;
   logic [3:0] m_shadow [12];
   int         pulses = 0;
   string      glyph [16];

   function automatic bit seg_on(string g, int xo, int yo);
      bit  top;
      bit  res;
      byte ch;
      top = (yo < 70);
      res = 1'b0;
      for (int i = 0; i < g.len(); i++) begin
         ch = g[i];
         case (ch)
            "a": res |= (yo < 10);
            "b": res |= (xo >= 70 && top);
            "c": res |= (xo >= 70 && !top);
            "d": res |= (yo >= 130);
            "e": res |= (xo < 10 && !top);
            "f": res |= (xo < 10 && top);
            "g": res |= (yo >= 65 && yo < 75);
            default: ;
         endcase
      end
      return res;
   endfunction

   function automatic logic [7:0] model_pix(int x, int y, bit d);
      int c, r, xo, yo, k;
      bit lit, inv;
      if (!d || x < 20 || y < 20) return 8'h00;
      c  = (x - 20) / 100;
      xo = (x - 20) % 100;
      r  = (y - 20) / 180;
      yo = (y - 20) % 180;
      if (c >= 6 || r >= 2 || xo >= 80 || yo >= 140) return 8'h00;
      k   = r*6 + c;
      lit = seg_on(glyph[m_shadow[k]], xo, yo);
      inv = 1'b0;
`ifdef DIGIT_TILE_CURSOR_EN
      inv = cursor_en && (k == int'(cursor_idx)) && (((pulses / 30) % 2) == 1);
`endif
      return (lit != inv) ? 8'hFF : 8'h00;
   endfunction

   task automatic chk8(string tag, logic [7:0] obs, logic [7:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic model_latch();
      for (int k = 0; k < 12; k++) m_shadow[k] = nums[4*(11-k) +: 4];
      pulses++;
   endtask

   // One pixel per clock; the output compared here belongs to the pixel driven two clocks earlier.
   task automatic step(int x, int y, bit d, bit fs, int want, string tag);
      exp_t e;
      @(negedge clk);
      if (q.size() >= 2) begin
         e = q.pop_front();
         chk8({e.tag, "_rgb"}, {vid.vga_r, vid.vga_g, vid.vga_b}, e.rgb);
         chk8({e.tag, "_de"}, {7'd0, vid.de_out}, {7'd0, e.de});
      end
      vid.sx          = 10'(x);
      vid.sy          = 10'(y);
      vid.de          = d;
      vid.frame_start = fs;
      e.rgb = (want >= 0) ? 8'(want) : model_pix(x, y, d);
      e.de  = d;
      e.tag = tag;
      q.push_back(e);
      if (fs) model_latch();
   endtask

   task automatic release_reset();
      exp_t z;
      vid.de          = 1'b0;
      vid.frame_start = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 12; k++) m_shadow[k] = 4'hF;
      pulses = 0;
      q.delete();
      z.rgb = 8'h00;
      z.de  = 1'b0;
      z.tag = "post_reset";
      q.push_back(z);
      q.push_back(z);
   endtask

   initial begin
      logic [63:0] r64;
      glyph[0] = "abcdef"; glyph[1] = "bc";     glyph[2] = "abdeg";   glyph[3] = "abcdg";
      glyph[4] = "bcfg";   glyph[5] = "acdfg";  glyph[6] = "acdefg";  glyph[7] = "abc";
      glyph[8] = "abcdefg"; glyph[9] = "abcdfg"; glyph[10] = "g";
      for (int i = 11; i < 16; i++) glyph[i] = "";

      vid.sx = 10'd0; vid.sy = 10'd0; vid.de = 1'b0; vid.frame_start = 1'b0;
      nums = 48'h0123456789A0;
      cursor_en = 1'b0;
      cursor_idx = 4'd0;
      release_reset();

      // Before any frame_start every tile is blank, whatever numbers_concat holds.
      step(25, 25, 1, 0, 0, "blank_t0_a");
      step(60, 90, 1, 0, 0, "blank_t0_g");
      step(598, 330, 1, 0, 0, "blank_t11_c");

      nums = 48'h8BBBBBBBBBBB;
      step(0, 0, 0, 1, 0, "latch8");
      step(25, 25, 1, 0, 255, "d8_a");
      step(60, 90, 1, 0, 255, "d8_g");
      step(60, 50, 1, 0, 0, "d8_hole");
      step(105, 25, 1, 0, 0, "d8_gap");
      step(99, 25, 1, 0, 255, "d8_right_edge");
      step(100, 25, 1, 0, 0, "d8_past_edge");
      step(25, 160, 1, 0, 0, "d8_below");

      nums = 48'hBBBBBBBBBBB1;
      step(0, 0, 0, 1, 0, "latch1");
      step(595, 230, 1, 0, 255, "d1_b");
      step(525, 230, 1, 0, 0, "d1_f_off");
      step(598, 330, 1, 0, 255, "d1_c");
      step(25, 25, 1, 0, 0, "d1_t0_blank");

      nums = 48'hABBBBBBBBBBB;
      step(0, 0, 0, 1, 0, "latchA");
      step(60, 90, 1, 0, 255, "minus_g");
      step(25, 25, 1, 0, 0, "minus_a");

      nums = 48'h8BBBBBBBBBBB;
      step(0, 0, 0, 1, 0, "latch8b");
      step(25, 25, 1, 0, 255, "shadow_before");
      nums = 48'hBBBBBBBBBBBB;
      step(25, 25, 1, 0, 255, "shadow_hold_a");
      step(60, 90, 1, 0, 255, "shadow_hold_g");
      step(25, 25, 1, 1, 255, "shadow_coincident_old");
      step(25, 25, 1, 0, 0, "shadow_after_new");

      nums = 48'h8BBBBBBBBBBB;
      step(0, 0, 0, 1, 0, "latch8c");
      step(25, 25, 0, 0, 0, "blank_de0");
      step(25, 25, 1, 0, 255, "de1_again");

      for (int f = 0; f < 4; f++) begin
         r64 = {$urandom, $urandom};
         nums = r64[47:0];
         step(0, 0, 0, 1, -1, "rand_latch");
         for (int i = 0; i < 150; i++) begin
            if (i == 75) begin
               r64 = {$urandom, $urandom};
               nums = r64[47:0];
            end
            step(int'($urandom_range(0, 639)), int'($urandom_range(0, 479)),
                 ($urandom_range(0, 9) != 0), 0, -1, "rand");
         end
      end

      // Asynchronous reset in the middle of a lit run.
      nums = 48'h8BBBBBBBBBBB;
      step(0, 0, 0, 1, 0, "latch8d");
      repeat (3) step(25, 25, 1, 0, 255, "pre_reset_lit");
      #2 rst_n = 1'b0;
      #1;
      chk8("reset_async_rgb", {vid.vga_r, vid.vga_g, vid.vga_b}, 8'h00);
      chk8("reset_async_de", {7'd0, vid.de_out}, 8'h00);
      release_reset();
      step(25, 25, 1, 0, 0, "after_reset_blank");
      step(60, 90, 1, 0, 0, "after_reset_blank_g");

      cursor_en = 1'b1;
      cursor_idx = 4'd0;
      step(0, 0, 0, 1, 0, "cur_latch");
      step(60, 50, 1, 0, 0, "cur_phase0_bg");
      step(25, 25, 1, 0, 255, "cur_phase0_fg");
      repeat (29) step(0, 0, 0, 1, 0, "cur_pulse");
`ifdef DIGIT_TILE_CURSOR_EN
      step(60, 50, 1, 0, 255, "cur_inv_bg");
      step(25, 25, 1, 0, 0, "cur_inv_fg");
      step(125, 25, 1, 0, 0, "cur_other_tile");
      step(105, 25, 1, 0, 0, "cur_gap");
      cursor_idx = 4'd12;
      step(60, 50, 1, 0, 0, "cur_idx12_bg");
      step(25, 25, 1, 0, 255, "cur_idx12_fg");
      cursor_idx = 4'd0;
      step(60, 50, 0, 0, 0, "cur_inv_de0");
      repeat (30) step(0, 0, 0, 1, 0, "cur_pulse2");
      step(60, 50, 1, 0, 0, "cur_back_bg");
      step(25, 25, 1, 0, 255, "cur_back_fg");
`else
      step(60, 50, 1, 0, 0, "nocur_bg");
      step(25, 25, 1, 0, 255, "nocur_fg");
`endif
      repeat (40) step(int'($urandom_range(0, 639)), int'($urandom_range(0, 479)), 1, 0, -1, "rand_cursor");
      step(0, 0, 0, 0, -1, "drain");
      step(0, 0, 0, 0, -1, "drain");
      step(0, 0, 0, 0, -1, "drain");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
